store_commit_buffer: RTL

Post-commit store buffer sitting directly downstream of the reorder buffer. When the ROB retires a store, this block captures the store's address, data and byte mask. It then drains entries in order to data memory through a request/response handshake, so a slow memory never stalls retirement unless the buffer is full. It also reports whether a pending load overlaps any buffered store, so the load unit can hold off until that store has reached memory.

---
 rtl/store_commit_buffer_if.sv | 35 +++
 rtl/store_commit_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/store_commit_buffer_if.sv
// Handshake bundle for the store commit buffer: ROB store commit, data-memory
// write channel, and the load-unit overlap query.
interface store_commit_buffer_if;
  logic        st_push;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        full;
  logic        empty;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_conflict;

  modport master (
    output st_push, st_addr, st_wdata, st_wmask,
    input  full, empty,
    input  dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_resp,
    output ld_addr, ld_rmask,
    input  ld_conflict
  );

  modport slave (
    input  st_push, st_addr, st_wdata, st_wmask,
    output full, empty,
    output dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_resp,
    input  ld_addr, ld_rmask,
    output ld_conflict
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: captures retired stores, drains them in order to
// data memory, and flags loads that overlap any store not yet written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no request on the memory port (dmem_wmask = 0)
// S_WRITE | head entry driven to memory, waiting for dmem_resp
module store_commit_buffer #(
  parameter int DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  store_commit_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [AW:0]   head;
  logic [AW:0]   tail;
  logic [AW:0]   count;
  logic [AW:0]   remain;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          full_w;
  logic          empty_w;
  logic          push_ok;
  logic          pop;
  logic          hit;

  // Only the word address is kept; byte offset is carried by the mask.
  logic [29:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  wmask_mem [DEPTH];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign full_w   = (head[AW] != tail[AW]) && (head_idx == tail_idx);
  assign empty_w  = (head == tail);
  assign count    = tail - head;

  // Full is judged on the pointers before this edge, so a same-cycle pop
  // never makes room for a same-cycle push.
  assign push_ok  = bus.st_push && !full_w;
  assign pop      = (state == S_WRITE) && bus.dmem_resp;
  assign remain   = count - {{AW{1'b0}}, 1'b1} + {{AW{1'b0}}, push_ok};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty_w) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (pop && (remain == '0)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[tail_idx]  <= bus.st_addr[31:2];
      wdata_mem[tail_idx] <= bus.st_wdata;
      wmask_mem[tail_idx] <= bus.st_wmask;
    end
  end

  always_comb begin
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_wmask = '0;
    if (state == S_WRITE) begin
      bus.dmem_addr  = {addr_mem[head_idx], 2'b00};
      bus.dmem_wdata = wdata_mem[head_idx];
      bus.dmem_wmask = wmask_mem[head_idx];
    end
  end

  // An entry is live when its distance from head is below the occupancy;
  // this covers the in-flight head and excludes this cycle's push.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] rel;
      rel = AW'(i) - head_idx;
      if (({1'b0, rel} < count) &&
          (addr_mem[i] == bus.ld_addr[31:2]) &&
          ((wmask_mem[i] & bus.ld_rmask) != 4'b0000))
        hit = 1'b1;
    end
  end

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.ld_conflict = hit;
endmodule
